// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer path: colour codes,
// default display geometry and the coordinate bus width.
package vga_pkg;

    localparam int COORD_BITS = 11;
    localparam int HD_DEFAULT = 1280;
    localparam int VD_DEFAULT = 1024;

    typedef enum bit [1:0] {
        BLACK = 2'd0,
        WHITE = 2'd1,
        BLUE  = 2'd2,
        GREEN = 2'd3
    } color_e;

endpackage

// File: rtl/vga_rect_draw.sv
// Rectangle-fill pixel writer: accepts one fill command at a time and emits
// one frame-buffer write per clock in raster order (x inner, y outer).
module vga_rect_draw
    import vga_pkg::*;
#(
    parameter int HD         = HD_DEFAULT,
    parameter int VD         = VD_DEFAULT,
    parameter int COORD_BITS = vga_pkg::COORD_BITS
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [COORD_BITS-1:0] cmd_x0_i,
    input  logic [COORD_BITS-1:0] cmd_y0_i,
    input  logic [COORD_BITS-1:0] cmd_x1_i,
    input  logic [COORD_BITS-1:0] cmd_y1_i,
    input  logic [1:0]            cmd_color_i,
    output logic                  we_o,
    output logic [1:0]            color_o,
    output logic [COORD_BITS-1:0] addr_x_o,
    output logic [COORD_BITS-1:0] addr_y_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_e;

    localparam logic [COORD_BITS-1:0] X_MAX = COORD_BITS'(HD - 1);
    localparam logic [COORD_BITS-1:0] Y_MAX = COORD_BITS'(VD - 1);

    function automatic logic [COORD_BITS-1:0] clamp_coord(
        input logic [COORD_BITS-1:0] v,
        input logic [COORD_BITS-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

    // An origin off-screen, or an origin beyond the clamped far corner, yields no pixels.
    function automatic logic cmd_rejected(
        input logic [COORD_BITS-1:0] x0,
        input logic [COORD_BITS-1:0] y0,
        input logic [COORD_BITS-1:0] x1c,
        input logic [COORD_BITS-1:0] y1c
    );
        return (x0 > X_MAX) || (y0 > Y_MAX) || (x0 > x1c) || (y0 > y1c);
    endfunction

    state_e                state_q,  state_d;
    logic [COORD_BITS-1:0] x_q,      x_d;
    logic [COORD_BITS-1:0] y_q,      y_d;
    logic [COORD_BITS-1:0] x0_q,     x0_d;
    logic [COORD_BITS-1:0] x1_q,     x1_d;
    logic [COORD_BITS-1:0] y1_q,     y1_d;
    logic [1:0]            color_q,  color_d;
    logic                  we_q,     we_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  err_q,    err_d;

    logic [COORD_BITS-1:0] x1c_s;
    logic [COORD_BITS-1:0] y1c_s;

    // Clamp the far corner of the incoming command to the visible area.
    always_comb begin
        x1c_s = clamp_coord(cmd_x1_i, X_MAX);
        y1c_s = clamp_coord(cmd_y1_i, Y_MAX);
    end

    // Next-state and registered-output logic for the IDLE/DRAW sequencer.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_rejected(cmd_x0_i, cmd_y0_i, x1c_s, y1c_s)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_DRAW;
                        x_d     = cmd_x0_i;
                        y_d     = cmd_y0_i;
                        x0_d    = cmd_x0_i;
                        x1_d    = x1c_s;
                        y1_d    = y1c_s;
                        color_d = cmd_color_i;
                        we_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    we_d   = 1'b0;
                    busy_d = 1'b0;
                end
            end
            S_DRAW: begin
                if (x_q < x1_q) begin
                    x_d = x_q + COORD_BITS'(1);
                end else if (y_q < y1_q) begin
                    x_d = x0_q;
                    y_d = y_q + COORD_BITS'(1);
                end else begin
                    // Last pixel was just written; drop the write strobe and flag completion.
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any command in progress.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= S_IDLE;
            x_q     <= {COORD_BITS{1'b0}};
            y_q     <= {COORD_BITS{1'b0}};
            x0_q    <= {COORD_BITS{1'b0}};
            x1_q    <= {COORD_BITS{1'b0}};
            y1_q    <= {COORD_BITS{1'b0}};
            color_q <= 2'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign we_o        = we_q;
    assign color_o     = color_q;
    assign addr_x_o    = x_q;
    assign addr_y_o    = y_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_vga_rect_draw.sv
// Directed bench for vga_rect_draw: reset, fills, clamp, reject,
// back-to-back commands and reset during a fill.
module tb_vga_rect_draw;
    import vga_pkg::*;

    localparam int CB = vga_pkg::COORD_BITS;

    logic          clk;
    logic          arstn;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [CB-1:0] cmd_x0_i;
    logic [CB-1:0] cmd_y0_i;
    logic [CB-1:0] cmd_x1_i;
    logic [CB-1:0] cmd_y1_i;
    logic [1:0]    cmd_color_i;
    logic          we_o;
    logic [1:0]    color_o;
    logic [CB-1:0] addr_x_o;
    logic [CB-1:0] addr_y_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int n_vec;
    int n_err;

    vga_rect_draw dut (
        .clk         (clk),
        .arstn       (arstn),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_x0_i    (cmd_x0_i),
        .cmd_y0_i    (cmd_y0_i),
        .cmd_x1_i    (cmd_x1_i),
        .cmd_y1_i    (cmd_y1_i),
        .cmd_color_i (cmd_color_i),
        .we_o        (we_o),
        .color_o     (color_o),
        .addr_x_o    (addr_x_o),
        .addr_y_o    (addr_y_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1, input int col);
        cmd_valid_i = 1'b1;
        cmd_x0_i    = CB'(x0);
        cmd_y0_i    = CB'(y0);
        cmd_x1_i    = CB'(x1);
        cmd_y1_i    = CB'(y1);
        cmd_color_i = 2'(col);
    endtask

    task automatic chk_pix(input string tag, input int x, input int y, input int col);
        chk({tag, ".we"},    32'(we_o),        32'd1);
        chk({tag, ".x"},     32'(addr_x_o),    32'(x));
        chk({tag, ".y"},     32'(addr_y_o),    32'(y));
        chk({tag, ".col"},   32'(color_o),     32'(col));
        chk({tag, ".busy"},  32'(busy_o),      32'd1);
        chk({tag, ".ready"}, 32'(cmd_ready_o), 32'd0);
        chk({tag, ".done"},  32'(done_o),      32'd0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done"},  32'(done_o),      32'd1);
        chk({tag, ".we"},    32'(we_o),        32'd0);
        chk({tag, ".busy"},  32'(busy_o),      32'd0);
        chk({tag, ".ready"}, 32'(cmd_ready_o), 32'd1);
    endtask

    // Issue a command and expect the rectangle (ex0,ey0)-(ex1,ey1) in raster order.
    task automatic rect(input string tag, input int x0, input int y0, input int x1, input int y1,
                        input int ex0, input int ey0, input int ex1, input int ey1, input int col);
        send(x0, y0, x1, y1, col);
        tick();
        cmd_valid_i = 1'b0;
        for (int y = ey0; y <= ey1; y++) begin
            for (int x = ex0; x <= ex1; x++) begin
                chk_pix(tag, x, y, col);
                tick();
            end
        end
        chk_done(tag);
        tick();
        chk({tag, ".done_clr"}, 32'(done_o), 32'd0);
        chk({tag, ".we_idle"},  32'(we_o),   32'd0);
    endtask

    task automatic reject(input string tag, input int x0, input int y0, input int x1, input int y1);
        send(x0, y0, x1, y1, 1);
        tick();
        cmd_valid_i = 1'b0;
        chk({tag, ".err"},   32'(err_o),       32'd1);
        chk({tag, ".we"},    32'(we_o),        32'd0);
        chk({tag, ".ready"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, ".busy"},  32'(busy_o),      32'd0);
        tick();
        chk({tag, ".err_clr"}, 32'(err_o),  32'd0);
        chk({tag, ".we2"},     32'(we_o),   32'd0);
        chk({tag, ".done"},    32'(done_o), 32'd0);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        arstn       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_x0_i    = '0;
        cmd_y0_i    = '0;
        cmd_x1_i    = '0;
        cmd_y1_i    = '0;
        cmd_color_i = 2'd0;
        #1 arstn = 1'b0;
        #2;
        chk("rst.we",    32'(we_o),     32'd0);
        chk("rst.color", 32'(color_o),  32'd0);
        chk("rst.x",     32'(addr_x_o), 32'd0);
        chk("rst.y",     32'(addr_y_o), 32'd0);
        chk("rst.busy",  32'(busy_o),   32'd0);
        chk("rst.done",  32'(done_o),   32'd0);
        chk("rst.err",   32'(err_o),    32'd0);
        #9 arstn = 1'b1;
        tick();
        chk("rst.ready", 32'(cmd_ready_o), 32'd1);

        // 1: single pixel
        rect("t1", 5, 7, 5, 7, 5, 7, 5, 7, int'(BLUE));
        // 2: 3x2 rectangle
        rect("t2", 10, 20, 12, 21, 10, 20, 12, 21, int'(WHITE));
        // 3: clamped to the bottom-right corner
        rect("t3", 1278, 1022, 2000, 2000, 1278, 1022, 1279, 1023, int'(GREEN));
        // 4: rejects
        reject("t4a", 30, 5, 20, 9);
        reject("t4b", 1280, 0, 1290, 0);
        reject("t4c", 0, 1024, 5, 1030);

        // 5: back-to-back, second command held during the first's last write
        send(3, 3, 4, 3, int'(WHITE));
        tick();
        cmd_valid_i = 1'b0;
        chk_pix("t5.a0", 3, 3, int'(WHITE));
        tick();
        chk_pix("t5.a1", 4, 3, int'(WHITE));
        send(0, 0, 1, 0, int'(BLUE));
        tick();
        chk_done("t5.gap");
        tick();
        cmd_valid_i = 1'b0;
        chk_pix("t5.b0", 0, 0, int'(BLUE));
        tick();
        chk_pix("t5.b1", 1, 0, int'(BLUE));
        tick();
        chk_done("t5.bdone");
        tick();

        // 6: reset after three writes of a 4x4 fill
        send(0, 0, 3, 3, int'(GREEN));
        tick();
        cmd_valid_i = 1'b0;
        chk_pix("t6.p0", 0, 0, int'(GREEN));
        tick();
        chk_pix("t6.p1", 1, 0, int'(GREEN));
        tick();
        chk_pix("t6.p2", 2, 0, int'(GREEN));
        #2 arstn = 1'b0;
        #1;
        chk("t6.rst_we",   32'(we_o),   32'd0);
        chk("t6.rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #2 arstn = 1'b1;
        tick();
        chk("t6.no_done", 32'(done_o),      32'd0);
        chk("t6.ready",   32'(cmd_ready_o), 32'd1);
        chk("t6.we_off",  32'(we_o),        32'd0);
        tick();
        chk("t6.no_done2", 32'(done_o), 32'd0);
        rect("t6.new", 2, 2, 2, 2, 2, 2, 2, 2, int'(WHITE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
